// File: rtl/button_event_if.sv
// button_event_if: valid/ready button event port plus a lost-press pulse.
interface button_event_if #(parameter int IDW = 2);
    logic           evt_valid;
    logic [IDW-1:0] evt_id;
    logic           evt_ready;
    logic           evt_drop;
    modport master(output evt_valid, output evt_id, output evt_drop, input evt_ready);
    modport slave(input evt_valid, input evt_id, input evt_drop, output evt_ready);
endinterface

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: shared-tick debounce, one-shot press events, round-robin onto one valid/ready port.
// Defining BTN_AUTOREPEAT_EN adds per-channel auto-repeat every REPEAT_TICKS ticks while held.
module button_event_arbiter #(
    parameter int N            = 4,
    parameter int IDW          = 2,
    parameter int TICK_DIV     = 666667,
    parameter int STABLE_TICKS = 3,
    parameter int REPEAT_TICKS = 50
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   sw,
    output logic [N-1:0]   db,
    button_event_if.master evt
);
    localparam int TW = $clog2(TICK_DIV);
    logic [TW-1:0]  tick_cnt;
    logic           tick;
    logic [3:0]     sc [N];
    logic [N-1:0]   db_q, pend, set, clr;
    logic [IDW-1:0] last_grant, win;
    logic           found, load;

    if (IDW != $clog2(N) || N < 2 || N > 16 || TICK_DIV < 2 || STABLE_TICKS < 1 ||
        STABLE_TICKS > 15 || REPEAT_TICKS < 1 || REPEAT_TICKS > 255) begin : g_bad_cfg
        $error("button_event_arbiter: invalid parameters");
    end

    assign tick = tick_cnt == TW'(TICK_DIV - 1);
    assign load = !evt.evt_valid || evt.evt_ready;

    always_ff @(posedge clk or negedge reset)
        if (!reset) tick_cnt <= '0;
        else tick_cnt <= tick ? '0 : tick_cnt + TW'(1);

    // Symmetric debounce: any agreeing cycle restarts the stability count.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            db   <= '0;
            db_q <= '0;
            for (int i = 0; i < N; i++) sc[i] <= '0;
        end else begin
            db_q <= db;
            for (int i = 0; i < N; i++)
                if (sw[i] == db[i]) sc[i] <= '0;
                else if (tick) begin
                    if (sc[i] == 4'(STABLE_TICKS - 1)) begin
                        db[i] <= ~db[i];
                        sc[i] <= '0;
                    end else sc[i] <= sc[i] + 4'd1;
                end
        end

`ifdef BTN_AUTOREPEAT_EN
    logic [7:0]   rc [N];
    logic [N-1:0] rep;

    always_comb begin
        rep = '0;
        for (int i = 0; i < N; i++) rep[i] = db[i] && tick && rc[i] == 8'(REPEAT_TICKS - 1);
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) for (int i = 0; i < N; i++) rc[i] <= '0;
        else for (int i = 0; i < N; i++) rc[i] <= (!db[i] || rep[i]) ? '0 : tick ? rc[i] + 8'd1 : rc[i];

    assign set = (db & ~db_q) | rep;
`else
    assign set = db & ~db_q;
`endif

    // Search starts just past the previous grant so every channel gets a turn.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= N; k++)
            if (!found && pend[(int'(last_grant) + k) % N]) begin
                found = 1'b1;
                win   = IDW'((int'(last_grant) + k) % N);
            end
        clr = (load && found) ? N'(1) << win : '0;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            pend          <= '0;
            evt.evt_valid <= 1'b0;
            evt.evt_id    <= '0;
            evt.evt_drop  <= 1'b0;
            last_grant    <= IDW'(N - 1);
        end else begin
            pend         <= (pend & ~clr) | set;
            evt.evt_drop <= |(set & pend);
            if (load) begin
                evt.evt_valid <= found;
                if (found) begin
                    evt.evt_id <= win;
                    last_grant <= win;
                end
            end
        end
endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Shared front end for the calculator's push-buttons. It debounces N raw switch inputs with one shared tick timer and a small per-channel counter. Each debounced press becomes a one-shot event, and the events from all channels are arbitrated round-robin onto a single valid/ready event port. Downstream, the key decoder / stack-queue command logic consumes one button event at a time.

## Interface
Parameters:
- N, 4, number of button channels (2..16)
- IDW, 2, event id width; must equal clog2(N) with a minimum of 1
- TICK_DIV, 666667, clk cycles per debounce tick (≥2)
- STABLE_TICKS, 3, consecutive ticks an input must disagree with db before db flips (1..15)
- REPEAT_TICKS, 50, auto-repeat period in ticks (only used with BTN_AUTOREPEAT_EN; 1..255)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- sw  in  N  raw, already-synchronised button levels, 1 = pressed
- db  out  N  debounced button levels
- evt_valid  out  1  event available
- evt_id  out  IDW  channel index of the presented event
- evt_ready  in  1  consumer accepts the event
- evt_drop  out  1  one-cycle pulse: a press was lost because its channel was already pending

## Operation
- Tick timer: tick_cnt counts 0..TICK_DIV-1 and wraps. Internal tick is high in the cycle tick_cnt == TICK_DIV-1. One timer is shared by all channels.
- Per-channel debounce, with stable counter sc[i] of 4 bits:
  - If sw[i] == db[i], sc[i] is cleared to 0 in any cycle, regardless of tick.
  - If sw[i] != db[i] and tick, sc[i] increments.
  - When the increment would reach STABLE_TICKS: db[i] toggles and sc[i] clears.
  - The same rule applies to press and release, so both directions are symmetric.
- Press detect: a 0→1 transition of db[i] sets pend[i] on the following edge.
  - If pend[i] is already 1 at that moment, pend[i] stays 1 and evt_drop pulses.
  - If a set and a clear of pend[i] coincide, the set wins.
- Arbitration:
  - The output register loads when evt_valid == 0, or when evt_valid && evt_ready (load-on-transfer, no bubble).
  - The winner is the lowest index at or after (last_grant+1) mod N with pend set.
  - Loading sets evt_valid=1 and evt_id=winner, clears pend[winner], and updates last_grant.
  - If there is a transfer and no pend bit is set, evt_valid drops to 0.
- Handshake rules:
  - evt_id is stable while evt_valid=1 and evt_ready=0.
  - evt_valid is never withdrawn without a transfer.
  - A channel may re-pend while its previous event is still held in the output register.

## Timing
- Reset state, all asynchronous:
  - tick_cnt=0, sc=0, db=0, pend=0
  - evt_valid=0, evt_id=0, evt_drop=0
  - last_grant=N-1, so channel 0 has first priority
- Latency from press to event:
  - db rises at edge E.
  - pend is set at E+1.
  - evt_valid is high after E+2 if the output register was empty.
- Debounce time lies between (STABLE_TICKS-1)·TICK_DIV+1 and STABLE_TICKS·TICK_DIV cycles of a stable level.
- tick_cnt is free-running and is not restarted by input activity.
- Reset mid-operation discards pending and presented events immediately, with no partial handshake.

## Configuration
- BTN_AUTOREPEAT_EN defined:
  - Each channel has an 8-bit repeat counter rc[i], cleared whenever db[i]==0.
  - While db[i]==1, rc[i] increments on tick.
  - When rc[i] reaches REPEAT_TICKS, the channel sets pend[i] exactly as a fresh press would (drop rule included), and rc[i] clears.
- BTN_AUTOREPEAT_EN not defined:
  - There is no repeat logic.
  - A held button produces exactly one event, and REPEAT_TICKS is ignored.

## Test plan
All scenarios use N=4, TICK_DIV=4, STABLE_TICKS=3, REPEAT_TICKS=5.
- Clean press: hold sw=4'b0010 for 20 cycles with evt_ready=1.
  - db[1] rises 9–12 cycles after the input change.
  - Exactly one beat with evt_valid=1, evt_id=1.
  - No repeat event without the macro.
- Bounce: sw[0] toggles every 3 cycles for 30 cycles, then settles high.
  - db[0] stays 0 during the toggling.
  - db[0] rises only after 3 stable ticks.
  - One event, evt_id=0.
- Round-robin under backpressure: channels 0, 2 and 3 press together, evt_ready=0 for 10 cycles, then 1.
  - evt_id=0 is held stable until evt_ready rises.
  - Events are then transferred in order 0, 2, 3 on consecutive cycles.
  - evt_valid falls after the third transfer.
- Drop: channel 1 presses, releases and presses again while evt_ready=0 and pend[1] is still set.
  - evt_drop pulses once.
  - Only one channel-1 event is pending behind the presented one.
- Reset mid-operation: assert reset while evt_valid=1 and pend≠0.
  - All outputs are 0 immediately.
  - After release, no stale event appears.
- With BTN_AUTOREPEAT_EN: hold sw[2] for 80 cycles with evt_ready=1.
  - The first event follows debounce.
  - Further evt_id=2 events occur every 20 cycles.
